// File: rtl/unison_rx_pkg.sv
// Shared register map and field positions for the unison readout receiver.
package unison_rx_pkg;

    localparam logic [7:0] OFS_STATUS = 8'h00;
    localparam logic [7:0] OFS_DATA   = 8'h04;
    localparam logic [7:0] OFS_CTRL   = 8'h08;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_UNDERFLOW = 3;
    localparam int ST_ENABLE    = 4;
    localparam int ST_LEVEL_LSB = 8;

    localparam int CTRL_ENABLE    = 0;
    localparam int CTRL_FLUSH     = 1;
    localparam int CTRL_CLR_STICKY = 2;

    typedef struct packed {
        logic       empty;
        logic       full;
        logic       overflow;
        logic       underflow;
        logic       enable;
        logic [7:0] level;
    } status_t;

    function automatic logic [31:0] pack_status(input status_t s);
        logic [31:0] w;
        w = '0;
        w[ST_EMPTY]               = s.empty;
        w[ST_FULL]                = s.full;
        w[ST_OVERFLOW]            = s.overflow;
        w[ST_UNDERFLOW]           = s.underflow;
        w[ST_ENABLE]              = s.enable;
        w[ST_LEVEL_LSB +: 8]      = s.level;
        return w;
    endfunction

endpackage

// File: rtl/unison_readout_rx_fifo.sv
// First-word-fall-through synchronous FIFO holding assembled readout frames.
module readout_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    // push/pop are single-cycle requests: a push while full is dropped unless
    // a pop is accepted in the same cycle; a pop while empty is ignored.
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/unison_readout_rx.sv
// Receiver for the digital_unison serial readout link: synchronises the strobe
// and lanes, assembles {I,Q} frame words, buffers them and exposes a Wishbone window.
module unison_readout_rx
    import unison_rx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          WORD_BITS  = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter int          IRQ_THRESH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        clk_master,
    input  logic        rstb,
    input  logic [1:0]  read_out_I,
    input  logic [1:0]  read_out_Q,
    output logic        irq
);

    localparam int LW    = $clog2(FIFO_DEPTH) + 1;
    localparam int NPAIR = WORD_BITS / 2;
    localparam int CNT_W = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NPAIR - 1);

    // Two-flop synchronisers; index [1] is the synchronised value.
    logic [1:0] cm_sync_q, rstb_sync_q;
    logic [1:0] i_s1_q, i_s2_q, q_s1_q, q_s2_q;
    logic       cm_prev_q;
    logic       strobe_edge;

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_BITS-1:0] sh_i_q, sh_i_d, sh_q_q, sh_q_d;
    logic [WORD_BITS+1:0] sh_i_ext, sh_q_ext;
    logic                 push_q, push_d;
    logic [31:0]          word_q, word_d;
    logic                 frame_active;

    logic        enable_q, enable_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;
    logic        ack_q;
    logic [31:0] dat_q, dat_d;
    logic        pop_q, pop_d;
    logic        irq_q, irq_d;

    logic        hit, ctrl_wr, flush, clr_sticky, ovf_set, unf_set;
    logic [7:0]  ofs;
    logic [31:0] rdata;
    logic [7:0]  level8;

    logic [31:0]   fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [LW-1:0] fifo_level;

    logic unused_ok;
    assign unused_ok = ^{wbs_dat_i[31:3], wbs_sel_i[3:1]};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cm_sync_q   <= '0;
            rstb_sync_q <= '0;
            i_s1_q      <= '0;
            i_s2_q      <= '0;
            q_s1_q      <= '0;
            q_s2_q      <= '0;
            cm_prev_q   <= 1'b0;
        end else begin
            cm_sync_q   <= {cm_sync_q[0], clk_master};
            rstb_sync_q <= {rstb_sync_q[0], rstb};
            i_s1_q      <= read_out_I;
            i_s2_q      <= i_s1_q;
            q_s1_q      <= read_out_Q;
            q_s2_q      <= q_s1_q;
            cm_prev_q   <= cm_sync_q[1];
        end
    end

    assign strobe_edge  = cm_sync_q[1] & ~cm_prev_q;
    assign frame_active = enable_q & rstb_sync_q[1] & ~flush;
    assign sh_i_ext     = {sh_i_q, i_s2_q};
    assign sh_q_ext     = {sh_q_q, q_s2_q};

    // Deserialiser: any loss of enable/rstb or a flush discards the partial frame.
    always_comb begin
        cnt_d  = cnt_q;
        sh_i_d = sh_i_q;
        sh_q_d = sh_q_q;
        push_d = 1'b0;
        word_d = word_q;
        if (!frame_active) begin
            cnt_d  = '0;
            sh_i_d = '0;
            sh_q_d = '0;
        end else if (strobe_edge) begin
            sh_i_d = sh_i_ext[WORD_BITS-1:0];
            sh_q_d = sh_q_ext[WORD_BITS-1:0];
            if (cnt_q == LAST_CNT) begin
                cnt_d  = '0;
                push_d = 1'b1;
                word_d = '0;
                word_d[16 +: WORD_BITS] = sh_i_ext[WORD_BITS-1:0];
                word_d[0  +: WORD_BITS] = sh_q_ext[WORD_BITS-1:0];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign ofs     = wbs_adr_i[7:0];
    assign hit     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
    assign ctrl_wr = hit & wbs_we_i & (ofs == OFS_CTRL) & wbs_sel_i[0];
    assign flush      = ctrl_wr & wbs_dat_i[CTRL_FLUSH];
    assign clr_sticky = ctrl_wr & wbs_dat_i[CTRL_CLR_STICKY];
    assign level8     = 8'(fifo_level);

    // A push into a full FIFO only overflows when no pop frees a slot that cycle.
    assign ovf_set = push_q & fifo_full & ~pop_q & ~flush;
    assign unf_set = hit & ~wbs_we_i & (ofs == OFS_DATA) & fifo_empty;

    always_comb begin
        status_t st;
        st.empty     = fifo_empty;
        st.full      = fifo_full;
        st.overflow  = overflow_q;
        st.underflow = underflow_q;
        st.enable    = enable_q;
        st.level     = level8;
        case (ofs)
            OFS_STATUS: rdata = pack_status(st);
            OFS_DATA:   rdata = fifo_empty ? 32'h0 : fifo_dout;
            OFS_CTRL:   rdata = {31'b0, enable_q};
            default:    rdata = 32'h0;
        endcase
    end

    always_comb begin
        dat_d       = (hit && !wbs_we_i) ? rdata : 32'h0;
        pop_d       = hit & ~wbs_we_i & (ofs == OFS_DATA) & ~fifo_empty;
        enable_d    = ctrl_wr ? wbs_dat_i[CTRL_ENABLE] : enable_q;
        overflow_d  = (overflow_q & ~clr_sticky) | ovf_set;
        underflow_d = (underflow_q & ~clr_sticky) | unf_set;
        irq_d       = enable_q & ((level8 >= 8'(IRQ_THRESH)) | overflow_q);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q       <= '0;
            sh_i_q      <= '0;
            sh_q_q      <= '0;
            push_q      <= 1'b0;
            word_q      <= '0;
            enable_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            pop_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sh_i_q      <= sh_i_d;
            sh_q_q      <= sh_q_d;
            push_q      <= push_d;
            word_q      <= word_d;
            enable_q    <= enable_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            ack_q       <= hit;
            dat_q       <= dat_d;
            pop_q       <= pop_d;
            irq_q       <= irq_d;
        end
    end

    readout_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .flush (flush),
        .push  (push_q),
        .pop   (pop_q),
        .din   (word_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_unison_readout_rx.sv
// Self-checking bench for unison_readout_rx: directed vectors, corner sequences
// and a randomized phase against a queue-based reference model.
module tb_unison_readout_rx;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        wb_rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] wdat, adr;
    logic        ack;
    logic [31:0] rdat_o;
    logic        clk_master, rstb;
    logic [1:0]  lane_i, lane_q;
    logic        irq;

    always #5 clk = ~clk;

    unison_readout_rx dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (wb_rst),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_dat_i  (wdat),
        .wbs_adr_i  (adr),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat_o),
        .clk_master (clk_master),
        .rstb       (rstb),
        .read_out_I (lane_i),
        .read_out_Q (lane_q),
        .irq        (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of frame words plus sticky/enable state.
    logic [31:0] exp_q[$];
    logic        m_ovf = 1'b0, m_unf = 1'b0, m_en = 1'b0;

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        logic [31:0] exp;
    } vec_t;
    vec_t tab[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void model_frame(input logic [15:0] fi, input logic [15:0] fq);
        if (exp_q.size() < DEPTH) exp_q.push_back({fi, fq});
        else m_ovf = 1'b1;
    endfunction

    function automatic logic [31:0] exp_status();
        int n;
        n = exp_q.size();
        return {16'b0, 8'(n), 3'b0, m_en, m_unf, m_ovf, (n == DEPTH), (n == 0)};
    endfunction

    function automatic logic exp_irq();
        return m_en & ((exp_q.size() >= 4) | m_ovf);
    endfunction

    task automatic send_pair(input logic [1:0] pi, input logic [1:0] pq);
        @(negedge clk);
        lane_i = pi;
        lane_q = pq;
        repeat (4) @(negedge clk);
        clk_master = 1'b1;
        repeat (5) @(negedge clk);
        clk_master = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] fi, input logic [15:0] fq);
        for (int k = 0; k < 8; k++) send_pair(fi[15-2*k -: 2], fq[15-2*k -: 2]);
        repeat (2) @(negedge clk);
    endtask

    task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic acked);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = 4'hF;
        acked = 1'b0;
        rd = '0;
        for (int c = 0; c < 4 && !acked; c++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1'b1;
                rd = rdat_o;
            end
        end
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (acked) begin
            @(posedge clk); #1;
            check("ack_single_cycle", {31'b0, ack}, 32'h0);
        end
    endtask

    task automatic rd_reg(input string name, input logic [7:0] ofs, output logic [31:0] d);
        logic a;
        wb(1'b0, BASE + 32'(ofs), 32'h0, d, a);
        check({name, "_ack"}, {31'b0, a}, 32'h1);
    endtask

    task automatic wr_ctrl(input logic [31:0] v);
        logic [31:0] d;
        logic a;
        wb(1'b1, BASE + 32'h8, v, d, a);
        check("ctrl_wr_ack", {31'b0, a}, 32'h1);
    endtask

    task automatic check_status(input string name);
        logic [31:0] d;
        rd_reg(name, 8'h00, d);
        check(name, d, exp_status());
    endtask

    task automatic read_data(input string name, output logic [31:0] d);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            e = 32'h0;
            m_unf = 1'b1;
        end else begin
            e = exp_q.pop_front();
        end
        rd_reg(name, 8'h04, d);
        check(name, d, e);
    endtask

    task automatic check_irq(input string name);
        repeat (2) @(negedge clk);
        check(name, {31'b0, irq}, {31'b0, exp_irq()});
    endtask

    initial begin
        logic [31:0] d;
        logic        a;
        logic [1:0]  pi_tab[8];
        logic [1:0]  pq_tab[8];
        logic [15:0] ri, rq;

        wb_rst = 1'b1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; wdat = '0; adr = '0;
        clk_master = 1'b0; rstb = 1'b1; lane_i = '0; lane_q = '0;

        tab[0] = '{16'h0001, 16'h8000, 32'h0001_8000};
        tab[1] = '{16'hFFFF, 16'h0000, 32'hFFFF_0000};
        tab[2] = '{16'h0000, 16'hFFFF, 32'h0000_FFFF};
        tab[3] = '{16'hAAAA, 16'h5555, 32'hAAAA_5555};
        tab[4] = '{16'h1234, 16'h5678, 32'h1234_5678};
        tab[5] = '{16'h8001, 16'h7FFE, 32'h8001_7FFE};
        tab[6] = '{16'hDEAD, 16'hBEEF, 32'hDEAD_BEEF};
        tab[7] = '{16'h0F0F, 16'hF0F0, 32'h0F0F_F0F0};
        tab[8] = '{16'hC0DE, 16'hCAFE, 32'hC0DE_CAFE};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'b0, ack}, 32'h0);
        check("rst_dat", rdat_o, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        wb_rst = 1'b0;
        check_status("status_after_reset");

        // Known frame given as explicit lane pairs.
        wr_ctrl(32'h1);
        m_en = 1'b1;
        rd_reg("ctrl_read", 8'h08, d);
        check("ctrl_read_val", d, 32'h1);
        pi_tab = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b11};
        pq_tab = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b01, 2'b00};
        for (int k = 0; k < 8; k++) send_pair(pi_tab[k], pq_tab[k]);
        repeat (2) @(negedge clk);
        exp_q.push_back(32'hA5C3_1234);
        check_status("pairs_status_level1");
        read_data("pairs_data", d);
        check("pairs_data_const", d, 32'hA5C3_1234);
        check_status("pairs_status_empty");

        // rstb drop mid-frame discards the partial frame.
        for (int k = 0; k < 5; k++) send_pair(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        rstb = 1'b0;
        repeat (8) @(negedge clk);
        rstb = 1'b1;
        repeat (6) @(negedge clk);
        send_frame(16'hFFFF, 16'h0001);
        model_frame(16'hFFFF, 16'h0001);
        check_status("rstb_abort_level1");
        read_data("rstb_abort_data", d);
        check("rstb_abort_const", d, 32'hFFFF_0001);

        // Nine frames into an eight-deep FIFO.
        for (int v = 0; v < 9; v++) begin
            send_frame(tab[v].i, tab[v].q);
            model_frame(tab[v].i, tab[v].q);
        end
        check_status("overflow_status");
        check_irq("overflow_irq");
        for (int v = 0; v < 8; v++) begin
            read_data($sformatf("tab_read%0d", v), d);
            check($sformatf("tab_vec%0d", v), d, tab[v].exp);
        end
        wr_ctrl(32'h5);
        m_ovf = 1'b0; m_unf = 1'b0;
        check_status("clr_sticky_status");
        check_irq("irq_cleared");

        // Empty read.
        read_data("underflow_data", d);
        check_status("underflow_status");
        wr_ctrl(32'h5);
        m_unf = 1'b0;

        // Final edge of a frame coincides with a DATA pop while full.
        for (int v = 0; v < 8; v++) begin
            ri = 16'($urandom); rq = 16'($urandom);
            send_frame(ri, rq);
            model_frame(ri, rq);
        end
        check_status("coincide_full");
        ri = 16'($urandom); rq = 16'($urandom);
        for (int k = 0; k < 7; k++) send_pair(ri[15-2*k -: 2], rq[15-2*k -: 2]);
        @(negedge clk);
        lane_i = ri[1:0];
        lane_q = rq[1:0];
        repeat (4) @(negedge clk);
        clk_master = 1'b1;
        repeat (2) @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h4; sel = 4'hF;
        a = 1'b0;
        d = '0;
        for (int c = 0; c < 4 && !a; c++) begin
            @(posedge clk); #1;
            if (ack) begin
                a = 1'b1;
                d = rdat_o;
            end
        end
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0;
        check("coincide_ack", {31'b0, a}, 32'h1);
        check("coincide_data", d, exp_q.pop_front());
        model_frame(ri, rq);
        repeat (3) @(negedge clk);
        clk_master = 1'b0;
        repeat (6) @(negedge clk);
        check_status("coincide_status");
        for (int v = 0; v < 8; v++) read_data($sformatf("coincide_drain%0d", v), d);
        check_status("coincide_drained");

        // Window decode.
        wb(1'b0, BASE + 32'h100, 32'h0, d, a);
        check("out_of_window_noack", {31'b0, a}, 32'h0);
        rd_reg("unmapped_read", 8'h0C, d);
        check("unmapped_val", d, 32'h0);
        wb(1'b1, BASE + 32'h4, 32'hFFFF_FFFF, d, a);
        check("data_write_ack", {31'b0, a}, 32'h1);
        check_status("data_write_ignored");

        // Disabled: edges do nothing.
        wr_ctrl(32'h0);
        m_en = 1'b0;
        send_frame(16'h1357, 16'h2468);
        check_status("disabled_level0");
        wr_ctrl(32'h1);
        m_en = 1'b1;

        // Flush mid-frame empties the FIFO and restarts framing.
        send_frame(16'h1111, 16'h2222);
        model_frame(16'h1111, 16'h2222);
        for (int k = 0; k < 3; k++) send_pair(2'b11, 2'b11);
        wr_ctrl(32'h3);
        exp_q.delete();
        check_status("flush_empty");
        send_frame(16'h4C4C, 16'h0E0E);
        model_frame(16'h4C4C, 16'h0E0E);
        read_data("flush_next_frame", d);
        check("flush_next_const", d, 32'h4C4C_0E0E);

        // Randomized mix of frames and reads.
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 2) != 0) begin
                ri = 16'($urandom); rq = 16'($urandom);
                send_frame(ri, rq);
                model_frame(ri, rq);
            end else begin
                read_data($sformatf("rand_read%0d", n), d);
            end
            if (n % 5 == 4) begin
                check_status($sformatf("rand_status%0d", n));
                check_irq($sformatf("rand_irq%0d", n));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
